feed_dispense_timer: RTL and testbench

- Downstream consumer of the option selector FSM in the pet-feeder datapath.
- Takes the held command levels count_enable, count_reset and interval_enable, and turns them into timed motor pulses.
- Supports a one-shot pour and a periodic interval-feeding loop, with a prescaled tick base.
- Counts completed pours for the display/status logic.

---
 rtl/feed_dispense_timer.sv | 149 ++++++++++++++
 tb/tb_feed_dispense_timer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/feed_dispense_timer.sv
// feed_dispense_timer: turns held option-FSM command levels into timed
// dispenser motor pulses (one-shot pour or periodic interval feeding),
// driven from a prescaled tick base, and counts completed pours.
// Optional pour limit is compiled in when the FEED_LIMIT_EN macro is defined.
module feed_dispense_timer #(
  parameter int TICK_DIV       = 50,
  parameter int POUR_TICKS     = 10,
  parameter int INTERVAL_TICKS = 40,
  parameter int MAX_POURS      = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       count_enable,
  input  logic       count_reset,
  input  logic       interval_enable,
  output logic       motor_on,
  output logic       busy,
  output logic [1:0] state_out,
  output logic [7:0] pour_count,
  output logic       limit_reached
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    POUR = 2'b01,
    WAIT = 2'b10
  } state_t;

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (POUR_TICKS > INTERVAL_TICKS) ? POUR_TICKS : INTERVAL_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] POUR_LAST  = TW'(POUR_TICKS - 1);
  localparam logic [TW-1:0] WAIT_LAST  = TW'(INTERVAL_TICKS - 1);

  state_t        state;
  logic [PW-1:0] prescaler;
  logic [TW-1:0] tick_count;
  logic          count_enable_prev;

  logic          tick;
  logic          enable_rise;
  logic [7:0]    pour_count_inc;
  logic          limit_hold;
  logic          limit_hit;

  assign tick           = (prescaler == PRESC_LAST);
  assign enable_rise    = count_enable & ~count_enable_prev;
  assign pour_count_inc = (pour_count == 8'hFF) ? pour_count : pour_count + 8'd1;

  assign busy      = (state != IDLE);
  assign state_out = state;

`ifdef FEED_LIMIT_EN
  logic limit_reg;
  assign limit_reached = limit_reg;
  assign limit_hold    = limit_reg;
  assign limit_hit     = (int'(pour_count_inc) >= MAX_POURS);
`else
  logic unused_limit_cfg;
  assign unused_limit_cfg = (MAX_POURS > 0);
  assign limit_reached    = 1'b0;
  assign limit_hold       = 1'b0;
  assign limit_hit        = 1'b0;
`endif

  // Main controller: state, motor drive, timers and pour counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= IDLE;
      motor_on          <= 1'b0;
      pour_count        <= 8'd0;
      prescaler         <= '0;
      tick_count        <= '0;
      count_enable_prev <= 1'b0;
`ifdef FEED_LIMIT_EN
      limit_reg         <= 1'b0;
`endif
    end else begin
      // Tracked even during count_reset, so a rise seen while clearing is consumed.
      count_enable_prev <= count_enable;
      if (count_reset) begin
        state      <= IDLE;
        motor_on   <= 1'b0;
        pour_count <= 8'd0;
        prescaler  <= '0;
        tick_count <= '0;
`ifdef FEED_LIMIT_EN
        limit_reg  <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            prescaler  <= '0;
            tick_count <= '0;
            if (!limit_hold && (enable_rise || interval_enable)) begin
              state    <= POUR;
              motor_on <= 1'b1;
            end
          end
          POUR: begin
            if (tick) begin
              prescaler <= '0;
              if (tick_count == POUR_LAST) begin
                motor_on   <= 1'b0;
                pour_count <= pour_count_inc;
                tick_count <= '0;
                state      <= interval_enable ? WAIT : IDLE;
`ifdef FEED_LIMIT_EN
                if (limit_hit) limit_reg <= 1'b1;
`endif
              end else begin
                tick_count <= tick_count + 1'b1;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
          WAIT: begin
            if (!interval_enable || limit_hold) begin
              state      <= IDLE;
              prescaler  <= '0;
              tick_count <= '0;
            end else if (tick) begin
              prescaler <= '0;
              if (tick_count == WAIT_LAST) begin
                state      <= POUR;
                motor_on   <= 1'b1;
                tick_count <= '0;
              end else begin
                tick_count <= tick_count + 1'b1;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            motor_on   <= 1'b0;
            prescaler  <= '0;
            tick_count <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_feed_dispense_timer.sv
// tb_feed_dispense_timer: scoreboard bench. Stimulus pushes expected motor
// edges (kind, cycle, pour_count) into a queue; a monitor pops and compares
// each time motor_on changes. Limit scenario runs when FEED_LIMIT_EN is defined.
module tb_feed_dispense_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       count_enable;
  logic       count_reset;
  logic       interval_enable;
  logic       motor_on;
  logic       busy;
  logic [1:0] state_out;
  logic [7:0] pour_count;
  logic       limit_reached;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c     = 0;

  typedef struct {
    bit rise;
    int t;
    int pc;
  } ev_t;

  ev_t exp_q[$];
  logic prev_motor = 1'b0;

  feed_dispense_timer #(
    .TICK_DIV(2),
    .POUR_TICKS(3),
    .INTERVAL_TICKS(4),
    .MAX_POURS(2)
  ) dut (
    .clock(clk),
    .reset(reset),
    .count_enable(count_enable),
    .count_reset(count_reset),
    .interval_enable(interval_enable),
    .motor_on(motor_on),
    .busy(busy),
    .state_out(state_out),
    .pour_count(pour_count),
    .limit_reached(limit_reached)
  );

  always #5 clk = ~clk;

  // Cycle counter: value seen at a negedge is the index of the preceding posedge.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every motor_on transition is a DUT transaction checked against the queue.
  always @(negedge clk) begin
    prev_motor <= motor_on;
    if (reset && (motor_on != prev_motor)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL motor_edge unexpected: actual motor_on=%0d cycle=%0d pour_count=%0d required no edge",
                 motor_on, cyc, pour_count);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if ((e.rise != motor_on) || (e.t != cyc) || (e.pc != int'(pour_count))) begin
          bad++;
          $display("FAIL motor_edge: actual motor_on=%0d cycle=%0d pour_count=%0d required motor_on=%0d cycle=%0d pour_count=%0d",
                   motor_on, cyc, pour_count, e.rise, e.t, e.pc);
        end else begin
          $display("motor edge ok: motor_on=%0d cycle=%0d pour_count=%0d", motor_on, cyc, pour_count);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end else begin
      $display("check ok: %s = %0d", name, act);
    end
  endtask

  task automatic expect_ev(input bit rise, input int t, input int pc);
    ev_t e;
    e.rise = rise;
    e.t    = t;
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    count_enable = 1'b0;
    count_reset = 1'b0;
    interval_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_motor", int'(motor_on), 0);
    chk("reset_pour_count", int'(pour_count), 0);
    chk("reset_state", int'(state_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_limit", int'(limit_reached), 0);
    reset = 1'b1;
    @(negedge clk);

`ifdef FEED_LIMIT_EN
    // Interval feeding stops after two pours; count_reset re-arms it.
    c = cyc;
    interval_enable = 1'b1;
    expect_ev(1'b1, c + 1, 0);
    expect_ev(1'b0, c + 7, 1);
    expect_ev(1'b1, c + 15, 1);
    expect_ev(1'b0, c + 21, 2);
    goto(c + 40);
    chk("limit_set", int'(limit_reached), 1);
    chk("limit_state_idle", int'(state_out), 0);
    chk("limit_pour_count", int'(pour_count), 2);
    chk("limit_motor_off", int'(motor_on), 0);
    count_reset = 1'b1;
    goto(c + 41);
    chk("limit_cleared", int'(limit_reached), 0);
    chk("limit_count_cleared", int'(pour_count), 0);
    count_reset = 1'b0;
    expect_ev(1'b1, c + 42, 0);
    expect_ev(1'b0, c + 48, 1);
    goto(c + 50);
    interval_enable = 1'b0;
    goto(c + 52);
    chk("resume_state_idle", int'(state_out), 0);
    chk("resume_pour_count", int'(pour_count), 1);
`else
    // One-shot pour on a rising edge, none while held, another after re-raise.
    c = cyc;
    count_enable = 1'b1;
    expect_ev(1'b1, c + 1, 0);
    expect_ev(1'b0, c + 7, 1);
    goto(c + 4);
    chk("oneshot_busy", int'(busy), 1);
    chk("oneshot_state_pour", int'(state_out), 1);
    goto(c + 12);
    chk("oneshot_state_idle", int'(state_out), 0);
    chk("oneshot_count1", int'(pour_count), 1);
    count_enable = 1'b0;
    goto(c + 14);
    count_enable = 1'b1;
    expect_ev(1'b1, c + 15, 1);
    expect_ev(1'b0, c + 21, 2);
    goto(c + 24);
    count_enable = 1'b0;
    chk("oneshot_count2", int'(pour_count), 2);

    // Interval mode: 6 on / 8 off, dropped during the fourth WAIT.
    goto(c + 26);
    c = cyc;
    interval_enable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      expect_ev(1'b1, c + 1 + 14 * k, 2 + k);
      expect_ev(1'b0, c + 7 + 14 * k, 3 + k);
    end
    goto(c + 51);
    chk("interval_state_wait", int'(state_out), 2);
    chk("interval_busy_wait", int'(busy), 1);
    chk("interval_count", int'(pour_count), 6);
    goto(c + 52);
    interval_enable = 1'b0;
    goto(c + 53);
    chk("interval_drop_idle", int'(state_out), 0);
    chk("interval_drop_busy", int'(busy), 0);

    // Interval dropped mid-pour: the pour completes and counts.
    goto(c + 55);
    c = cyc;
    interval_enable = 1'b1;
    expect_ev(1'b1, c + 1, 6);
    expect_ev(1'b0, c + 7, 7);
    goto(c + 3);
    interval_enable = 1'b0;
    goto(c + 8);
    chk("midpour_drop_idle", int'(state_out), 0);
    chk("midpour_drop_count", int'(pour_count), 7);

    // count_reset mid-pour; a count_enable rise under reset is ignored.
    goto(c + 10);
    c = cyc;
    count_enable = 1'b1;
    expect_ev(1'b1, c + 1, 7);
    expect_ev(1'b0, c + 5, 0);
    goto(c + 4);
    count_reset = 1'b1;
    goto(c + 5);
    chk("creset_state", int'(state_out), 0);
    chk("creset_count", int'(pour_count), 0);
    chk("creset_motor", int'(motor_on), 0);
    goto(c + 6);
    count_enable = 1'b0;
    goto(c + 7);
    count_enable = 1'b1;
    goto(c + 10);
    count_reset = 1'b0;
    goto(c + 16);
    chk("creset_hold_state", int'(state_out), 0);
    chk("creset_hold_count", int'(pour_count), 0);
    count_enable = 1'b0;

    // count_enable rise together with interval_enable: one pour, then interval continues.
    goto(c + 18);
    c = cyc;
    count_enable = 1'b1;
    interval_enable = 1'b1;
    expect_ev(1'b1, c + 1, 0);
    expect_ev(1'b0, c + 7, 1);
    expect_ev(1'b1, c + 15, 1);
    expect_ev(1'b0, c + 21, 2);
    goto(c + 23);
    interval_enable = 1'b0;
    count_enable = 1'b0;
    goto(c + 24);
    chk("combo_state_idle", int'(state_out), 0);
    chk("combo_count", int'(pour_count), 2);
    chk("no_limit_flag", int'(limit_reached), 0);
`endif

    goto(cyc + 5);
    chk("pending_events", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
